// File: rtl/post_switch.sv
// post_switch: GMII byte-stream pass-through that, on trigger, injects a burst of
// broadcast RARP frames sourced from mac_address so downstream switches relearn
// which port the station sits behind.
// Optional build macro POST_SWITCH_FCS_EN: append the Ethernet CRC-32 to each
// injected frame (72 clocks of down_dv instead of 68).
module post_switch #(
  parameter int unsigned ARP_REPEAT = 3,
  parameter int unsigned ARP_GAP    = 96,
  parameter int unsigned IFG        = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] mac_address,
  input  logic        mac_valid,
  input  logic        trigger,
  input  logic [7:0]  up_data,
  input  logic        up_dv,
  input  logic        up_er,
  output logic [7:0]  down_data,
  output logic        down_dv,
  output logic        down_er
);

`ifdef POST_SWITCH_FCS_EN
  localparam int unsigned FrameLen = 72;
`else
  localparam int unsigned FrameLen = 68;
`endif
  localparam int unsigned GapW = $clog2(ARP_GAP + 1);
  localparam int unsigned IfgW = $clog2(IFG + 1);
  localparam logic [GapW-1:0] GapMax   = GapW'(ARP_GAP);
  // The WAIT->INJECT transition clock is itself one more idle output clock.
  localparam logic [GapW-1:0] GapStart = GapW'(ARP_GAP - 1);
  localparam logic [IfgW-1:0] IfgMax   = IfgW'(IFG);
  localparam logic [6:0]      LastPos  = 7'(FrameLen - 1);

  typedef enum logic [1:0] {StPass, StWait, StInject} state_e;

  state_e          state_q, state_d;
  logic [7:0]      pending_q, pending_d;
  logic [6:0]      pos_q, pos_d;
  logic [47:0]     mac_q, mac_d;
  logic [GapW-1:0] gap_q, gap_d;    // consecutive idle clocks on down_dv
  logic [IfgW-1:0] idle_q, idle_d;  // consecutive idle clocks seen on up_dv
  logic [IfgW-1:0] tail_q, tail_d;  // guard window after an injected frame
  logic            up_dv_q, drop_q, drop_now;
  logic            start, frame_end, start_ok;
  logic [7:0]      inj_byte, data_d;
  logic            dv_d, er_d;

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] idx);
    logic [47:0] s;
    s = m << {idx, 3'b000};
    return s[47:40];
  endfunction

`ifdef POST_SWITCH_FCS_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Running CRC over dst..pad; seeded when a frame starts.
  always_comb begin
    crc_d = crc_q;
    if (start) begin
      crc_d = '1;
    end else if (state_q == StInject && pos_q >= 7'd8 && pos_q < 7'd68) begin
      crc_d = crc_step(crc_q, inj_byte);
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= '0;
    else      crc_q <= crc_d;
  end
`endif

  // Injected RARP byte for the current frame position.
  always_comb begin
    inj_byte = 8'h00;
    if (pos_q < 7'd7)                          inj_byte = 8'h55;
    else if (pos_q == 7'd7)                    inj_byte = 8'hD5;
    else if (pos_q < 7'd14)                    inj_byte = 8'hFF;
    else if (pos_q < 7'd20)                    inj_byte = mac_byte(mac_q, 3'(pos_q - 7'd14));
    else if (pos_q == 7'd20)                   inj_byte = 8'h80;
    else if (pos_q == 7'd21)                   inj_byte = 8'h35;
    else if (pos_q == 7'd23)                   inj_byte = 8'h01;
    else if (pos_q == 7'd24)                   inj_byte = 8'h08;
    else if (pos_q == 7'd26)                   inj_byte = 8'h06;
    else if (pos_q == 7'd27)                   inj_byte = 8'h04;
    else if (pos_q == 7'd29)                   inj_byte = 8'h03;
    else if (pos_q >= 7'd30 && pos_q < 7'd36)  inj_byte = mac_byte(mac_q, 3'(pos_q - 7'd30));
    else if (pos_q >= 7'd40 && pos_q < 7'd46)  inj_byte = mac_byte(mac_q, 3'(pos_q - 7'd40));
`ifdef POST_SWITCH_FCS_EN
    else if (pos_q >= 7'd68) begin
      unique case (pos_q[1:0])
        2'd0:    inj_byte = ~crc_q[7:0];
        2'd1:    inj_byte = ~crc_q[15:8];
        2'd2:    inj_byte = ~crc_q[23:16];
        default: inj_byte = ~crc_q[31:24];
      endcase
    end
`endif
  end

  assign start_ok = mac_valid && !up_dv && (idle_q >= IfgMax) && (gap_q >= GapStart);

  // A frame rising during injection or its trailing IFG guard is dropped whole.
  assign drop_now = up_dv && (drop_q || (state_q == StInject) ||
                              (!up_dv_q && (tail_q != '0)));

  // Next-state: FSM, pending count, counters and registered outputs.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    mac_d     = mac_q;
    start     = 1'b0;
    frame_end = 1'b0;
    tail_d    = (tail_q != '0) ? tail_q - IfgW'(1) : '0;

    unique case (state_q)
      StPass: if (pending_q != '0) state_d = StWait;
      StWait: begin
        if (pending_q == '0) begin
          state_d = StPass;
        end else if (start_ok) begin
          state_d = StInject;
          pos_d   = '0;
          mac_d   = mac_address;
          start   = 1'b1;
        end
      end
      StInject: begin
        pos_d = pos_q + 7'd1;
        if (pos_q == LastPos) begin
          frame_end = 1'b1;
          pos_d     = '0;
          tail_d    = IfgMax;
        end
      end
      default: state_d = StPass;
    endcase

    if (!mac_valid)     pending_d = '0;
    else if (trigger)   pending_d = 8'(ARP_REPEAT);
    else if (frame_end) pending_d = pending_q - 8'd1;
    else                pending_d = pending_q;

    if (frame_end) state_d = (pending_d != '0) ? StWait : StPass;

    if (state_q == StInject) begin
      data_d = inj_byte;
      dv_d   = 1'b1;
      er_d   = 1'b0;
    end else if (drop_now) begin
      data_d = '0;
      dv_d   = 1'b0;
      er_d   = 1'b0;
    end else begin
      data_d = up_data;
      dv_d   = up_dv;
      er_d   = up_er;
    end

    gap_d  = dv_d  ? '0 : ((gap_q == GapMax)  ? gap_q  : gap_q + GapW'(1));
    idle_d = up_dv ? '0 : ((idle_q == IfgMax) ? idle_q : idle_q + IfgW'(1));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StPass;
      pending_q <= '0;
      pos_q     <= '0;
      mac_q     <= '0;
      gap_q     <= '0;
      idle_q    <= '0;
      tail_q    <= '0;
      up_dv_q   <= 1'b0;
      drop_q    <= 1'b0;
      down_data <= '0;
      down_dv   <= 1'b0;
      down_er   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pos_q     <= pos_d;
      mac_q     <= mac_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      tail_q    <= tail_d;
      up_dv_q   <= up_dv;
      drop_q    <= drop_now;
      down_data <= data_d;
      down_dv   <= dv_d;
      down_er   <= er_d;
    end
  end

endmodule

// File: tb/tb_post_switch.sv
// Scoreboard bench for post_switch: stimulus pushes expected downstream frames,
// a negedge monitor assembles down_dv runs into frames and checks them.
module tb_post_switch;
  localparam int unsigned ArpRepeat = 3;
  localparam int unsigned ArpGap    = 96;
  localparam int unsigned Ifg       = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] mac_address;
  logic        mac_valid, trigger;
  logic [7:0]  up_data;
  logic        up_dv, up_er;
  logic [7:0]  down_data;
  logic        down_dv, down_er;

  always #5 clk = ~clk;

  post_switch #(.ARP_REPEAT(ArpRepeat), .ARP_GAP(ArpGap), .IFG(Ifg)) dut (
    .clk(clk), .rst(rst), .mac_address(mac_address), .mac_valid(mac_valid),
    .trigger(trigger), .up_data(up_data), .up_dv(up_dv), .up_er(up_er),
    .down_data(down_data), .down_dv(down_dv), .down_er(down_er)
  );

  typedef struct {
    int len;
    int start;  // required first-byte cycle, -1 = don't care
    int gap;    // required idle clocks before frame, -1 = don't care
  } frame_t;

  frame_t     exp_q[$];
  logic [8:0] exp_b[$];  // {er, data} of all expected frames, in order
  logic [8:0] tx[$];     // frame being built for upstream
  logic [8:0] cap[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int cap_start = 0;
  int last_end = -1000;
  bit in_frame = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc32(input logic [7:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic expect_rarp(input logic [47:0] mac, input int gap);
    logic [7:0] p[$];
    frame_t f;
    repeat (6) p.push_back(8'hFF);
    for (int i = 0; i < 6; i++) p.push_back(mac[47-8*i -: 8]);
    p.push_back(8'h80); p.push_back(8'h35); p.push_back(8'h00); p.push_back(8'h01);
    p.push_back(8'h08); p.push_back(8'h00); p.push_back(8'h06); p.push_back(8'h04);
    p.push_back(8'h00); p.push_back(8'h03);
    for (int i = 0; i < 6; i++) p.push_back(mac[47-8*i -: 8]);
    repeat (4) p.push_back(8'h00);
    for (int i = 0; i < 6; i++) p.push_back(mac[47-8*i -: 8]);
    repeat (4) p.push_back(8'h00);
    repeat (18) p.push_back(8'h00);
`ifdef POST_SWITCH_FCS_EN
    begin
      logic [31:0] fcs;
      fcs = crc32(p);
      for (int k = 0; k < 4; k++) p.push_back(fcs[8*k +: 8]);
    end
`endif
    repeat (7) exp_b.push_back(9'h055);
    exp_b.push_back(9'h0D5);
    foreach (p[i]) exp_b.push_back({1'b0, p[i]});
    f.len = 8 + p.size();
    f.start = -1;
    f.gap = gap;
    exp_q.push_back(f);
  endtask

  task automatic expect_burst(input logic [47:0] mac, input int n);
    for (int i = 0; i < n; i++) expect_rarp(mac, (i == 0) ? -1 : int'(ArpGap));
  endtask

  // ---------------- monitor ----------------
  task automatic check_frame();
    frame_t e;
    logic [8:0] x;
    int bad, first;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_frame: got %0d-byte frame at cycle %0d, required none",
               cap.size(), cap_start);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (cap.size() != e.len) begin
      errors++;
      $display("FAIL frame_len: got %0d at cycle %0d, required %0d", cap.size(), cap_start, e.len);
    end
    bad = 0;
    first = -1;
    for (int i = 0; i < e.len; i++) begin
      x = exp_b.pop_front();
      if (i >= cap.size() || cap[i] !== x) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_bytes: %0d bytes differ, first at %0d got %h required %h", bad, first,
               (first < cap.size()) ? cap[first] : 9'h1FF, exp_b.size() >= 0 ? 9'h000 : 9'h000);
    end
    if (e.start >= 0) begin
      checks++;
      if (cap_start != e.start) begin
        errors++;
        $display("FAIL latency: frame started cycle %0d, required %0d", cap_start, e.start);
      end
    end
    if (e.gap >= 0) begin
      checks++;
      if (cap_start - last_end - 1 != e.gap) begin
        errors++;
        $display("FAIL frame_gap: got %0d idle clocks, required %0d", cap_start - last_end - 1,
                 e.gap);
      end
    end
    cap.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cap.delete();
      in_frame = 1'b0;
    end else if (down_dv) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        cap_start = cyc;
      end
      cap.push_back({down_er, down_data});
    end else if (in_frame) begin
      in_frame = 1'b0;
      check_frame();
      last_end = cyc - 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    up_dv = 1'b0; up_er = 1'b0; up_data = 8'h00;
    repeat (n) tick();
  endtask

  task automatic send_tx(input bit pass);
    frame_t f;
    if (pass) begin
      f.len = tx.size();
      f.start = cyc + 1;
      f.gap = -1;
      exp_q.push_back(f);
      foreach (tx[i]) exp_b.push_back(tx[i]);
    end
    foreach (tx[i]) begin
      up_dv = 1'b1; up_er = tx[i][8]; up_data = tx[i][7:0];
      tick();
    end
    up_dv = 1'b0; up_er = 1'b0; up_data = 8'h00;
    tx.delete();
  endtask

  task automatic make_rand(input int len, input bit with_er);
    tx.delete();
    repeat (7) tx.push_back(9'h055);
    tx.push_back(9'h0D5);
    for (int i = 8; i < len; i++) begin
      tx.push_back({with_er && ($urandom_range(0, 7) == 0), 8'($urandom)});
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || in_frame) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expected frames still pending, required 0", exp_q.size());
    end
  endtask

  task automatic wait_dv(input int budget);
    int n;
    n = 0;
    while (!down_dv && n < budget) begin
      tick();
      n++;
    end
    if (!down_dv) begin
      checks++;
      errors++;
      $display("FAIL wait_dv: down_dv got 0 after %0d clocks, required 1", budget);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (down_dv !== 1'b0 || down_data !== 8'h00 || down_er !== 1'b0) begin
      errors++;
      $display("FAIL %s: got dv=%b data=%h er=%b, required dv=0 data=00 er=0", name, down_dv,
               down_data, down_er);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [47:0] m;
    rst = 1'b0; mac_address = '0; mac_valid = 1'b0; trigger = 1'b0;
    up_data = 8'h00; up_dv = 1'b0; up_er = 1'b0;
    repeat (3) tick();
    check_zero("reset_state");
    rst = 1'b1;
    idle(5);
    check_zero("post_reset_idle");

    // Pass-through of a counting frame with mac_valid low.
    tx.delete();
    repeat (7) tx.push_back(9'h055);
    tx.push_back(9'h0D5);
    for (int i = 0; i < 60; i++) tx.push_back({1'b0, 8'(i)});
    send_tx(1'b1);
    idle(20);

    // Trigger ignored while mac_valid is low.
    mac_address = 48'h1122_33AA_BBCC;
    pulse_trigger();
    idle(300);
    make_rand(64, 1'b0);
    send_tx(1'b1);
    idle(20);

    // Burst from idle with a fixed MAC.
    mac_valid = 1'b1;
    expect_burst(48'h1122_33AA_BBCC, ArpRepeat);
    pulse_trigger();
    wait_empty(2000);
    idle(300);

    // Long frame with error bits, then a run of random frames with short gaps.
    make_rand(128, 1'b1);
    send_tx(1'b1);
    for (int n = 0; n < 6; n++) begin
      idle($urandom_range(1, 15));
      make_rand($urandom_range(20, 100), 1'b1);
      send_tx(1'b1);
    end
    idle(20);
    wait_empty(200);

    // Burst with a random MAC.
    m = {$urandom, $urandom};
    mac_address = m;
    expect_burst(m, ArpRepeat);
    pulse_trigger();
    wait_empty(2000);
    idle(200);

    // Upstream frame starting mid-injection is dropped whole.
    m = {$urandom, $urandom};
    mac_address = m;
    expect_burst(m, ArpRepeat);
    pulse_trigger();
    wait_dv(500);
    idle(10);
    make_rand(30, 1'b0);
    send_tx(1'b0);
    wait_empty(2000);
    idle(20);
    make_rand(50, 1'b1);
    send_tx(1'b1);
    idle(20);
    wait_empty(200);

    // mac_valid falling mid-frame: that frame completes, no more follow.
    expect_burst(m, 1);
    pulse_trigger();
    wait_dv(500);
    idle(5);
    mac_valid = 1'b0;
    wait_empty(500);
    idle(400);
    mac_valid = 1'b1;

    // Asynchronous reset in the middle of an injected frame.
    expect_burst(m, ArpRepeat);
    pulse_trigger();
    wait_dv(500);
    idle(20);
    #2;
    rst = 1'b0;
    #1;
    check_zero("reset_mid_inject");
    #2;
    exp_q.delete();
    exp_b.delete();
    tick();
    tick();
    rst = 1'b1;
    idle(300);
    make_rand(40, 1'b1);
    send_tx(1'b1);
    idle(300);
    wait_empty(200);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected frames never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
